// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Pure definitions, no logic or latency.
// No flow control lives here.
package loader_pkg;

  // Frame-level loader states
  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DATA,
    CSUM
  } loader_state_t;

  // Byte-level receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer and mid-bit sampling.
// Latency: valid/frame_err pulse in the cycle the stop bit is sampled.
// No backpressure: each byte is presented for exactly one cycle.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  // State register; the synchronizer and edge history reset to the idle (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next state: start-edge detect, glitch reject at mid-start, LSB-first sampling
  always_comb begin
    state_d = state_q;
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: byte strobe or framing error in the stop-bit sampling cycle
  always_comb begin
    data      = shift_q;
    valid     = (state_q == RX_STOP) && (cnt_q == FULL_CNT) && sync2_q;
    frame_err = (state_q == RX_STOP) && (cnt_q == FULL_CNT) && !sync2_q;
  end

endmodule

// File: rtl/iram_uart_loader.sv
// Loads a framed program image from UART into IRAM, holding the core in reset meanwhile.
// Latency: IRAM write and status outputs register 1 cycle after the relevant byte strobe.
// No backpressure: IRAM accepts every write; UART bytes cannot be stalled.
module iram_uart_loader
  import loader_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int IRAM_ADDR_BITS = 8,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [WIDTH-1:0]          iram_din,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int BPW = WIDTH / 8;
  localparam logic [7:0] LAST_BYTE = 8'(BPW - 1);
  // A count byte of zero means a full IRAM, never more than 256 words
  localparam logic [8:0] ZERO_N_WORDS =
    (IRAM_ADDR_BITS >= 8) ? 9'd256 : 9'(1 << IRAM_ADDR_BITS);

  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .valid     (rx_vld),
    .frame_err (rx_ferr)
  );

  loader_state_t             state_q, state_d;
  logic [8:0]                n_q, n_d;
  logic [8:0]                wcnt_q, wcnt_d;
  logic [IRAM_ADDR_BITS-1:0] widx_q, widx_d;
  logic [7:0]                bcnt_q, bcnt_d;
  logic [WIDTH-1:0]          word_q, word_d;
  logic [7:0]                xor_q, xor_d;
  logic [IRAM_ADDR_BITS-1:0] iram_wa_q, iram_wa_d;
  logic                      iram_wen_q, iram_wen_d;
  logic [WIDTH-1:0]          iram_din_q, iram_din_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [WIDTH-1:0]          word_next;

  // State register for the frame FSM and its datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      wcnt_q     <= '0;
      widx_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      iram_wa_q  <= '0;
      iram_wen_q <= 1'b0;
      iram_din_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      widx_q     <= widx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      xor_q      <= xor_d;
      iram_wa_q  <= iram_wa_d;
      iram_wen_q <= iram_wen_d;
      iram_din_q <= iram_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state: header/count/data/checksum parsing, word assembly and write issue
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    widx_d     = widx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    xor_d      = xor_q;
    iram_wa_d  = iram_wa_q;
    iram_wen_d = 1'b0;
    iram_din_d = iram_din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    word_next  = (word_q << 8) | WIDTH'(rx_data);

    // A broken byte aborts any frame in flight; idle line noise is ignored
    if (rx_ferr && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end else if (rx_vld) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == LOADER_HDR) begin
            state_d = COUNT;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            xor_d   = '0;
            widx_d  = '0;
            wcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
        COUNT: begin
          n_d     = (rx_data == 8'd0) ? ZERO_N_WORDS : {1'b0, rx_data};
          state_d = DATA;
        end
        DATA: begin
          word_d = word_next;
          xor_d  = xor_q ^ rx_data;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d     = '0;
            iram_wen_d = 1'b1;
            iram_wa_d  = widx_q;
            iram_din_d = word_next;
            widx_d     = widx_q + 1'b1;
            wcnt_d     = wcnt_q + 9'd1;
            if (wcnt_q + 9'd1 == n_q) state_d = CSUM;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
        CSUM: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rx_data == xor_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    iram_wa  = iram_wa_q;
    iram_wen = iram_wen_q;
    iram_din = iram_din_q;
    busy     = busy_q;
    done     = done_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_iram_uart_loader.sv
// Directed bench for the UART IRAM loader at 16 clocks per bit.
// Bytes are bit-banged on rx; IRAM writes and done pulses are logged on the falling edge.
// Expected values are hand-computed per frame.
module tb_iram_uart_loader;
  import loader_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  iram_wa;
  logic        iram_wen;
  logic [15:0] iram_din;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errs   = 0;

  // Write / done log filled by the monitor
  int          nwr = 0;
  int          ndone = 0;
  int          nconsec = 0;
  logic        wen_prev = 1'b0;
  logic [7:0]  wr_wa [0:1023];
  logic [15:0] wr_din[0:1023];

  iram_uart_loader #(
    .WIDTH          (16),
    .IRAM_ADDR_BITS (8),
    .CLKS_PER_BIT   (CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .iram_wa  (iram_wa),
    .iram_wen (iram_wen),
    .iram_din (iram_din),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Log every write and done pulse; count back-to-back write enables
  always @(negedge clk) begin
    if (iram_wen) begin
      if (nwr < 1024) begin
        wr_wa[nwr]  = iram_wa;
        wr_din[nwr] = iram_din;
      end
      nwr = nwr + 1;
    end
    if (iram_wen && wen_prev) nconsec = nconsec + 1;
    wen_prev = iram_wen;
    if (done) ndone = ndone + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 8N1 byte; stop bit held long enough for the mid-bit sample, then brief idle
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
    check_eq({tag, "_wa"},  32'(wr_wa[idx]),  32'(a));
    check_eq({tag, "_din"}, 32'(wr_din[idx]), 32'(d));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wen"},  32'(iram_wen), 32'd0);
    check_eq({tag, "_wa"},   32'(iram_wa),  32'd0);
    check_eq({tag, "_din"},  32'(iram_din), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy),     32'd0);
    check_eq({tag, "_done"}, 32'(done),     32'd0);
    check_eq({tag, "_err"},  32'(err),      32'd0);
  endtask

  int base_wr;
  int base_done;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Good two-word frame: 12^34^AB^CD = 40
    base_wr = nwr; base_done = ndone;
    check_eq("s1_busy_pre", 32'(busy), 32'd0);
    send_byte(8'hA5);
    check_eq("s1_busy_hdr", 32'(busy), 32'd1);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check_eq("s1_busy_mid", 32'(busy), 32'd1);
    send_byte(8'hAB); send_byte(8'hCD);
    check_eq("s1_busy_data", 32'(busy), 32'd1);
    send_byte(8'h40);
    check_eq("s1_nwr", 32'(nwr - base_wr), 32'd2);
    check_wr("s1_w0", base_wr, 8'd0, 16'h1234);
    check_wr("s1_w1", base_wr + 1, 8'd1, 16'hABCD);
    check_eq("s1_done", 32'(ndone - base_done), 32'd1);
    check_eq("s1_err", 32'(err), 32'd0);
    check_eq("s1_busy_end", 32'(busy), 32'd0);
    check_eq("s1_wa_hold", 32'(iram_wa), 32'd1);
    check_eq("s1_din_hold", 32'(iram_din), 32'hABCD);

    // Bad checksum, then a good frame clears err
    base_wr = nwr; base_done = ndone;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h00);
    check_eq("s2_nwr", 32'(nwr - base_wr), 32'd2);
    check_eq("s2_err", 32'(err), 32'd1);
    check_eq("s2_done", 32'(ndone - base_done), 32'd0);
    check_eq("s2_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    check_eq("s2_err_clr", 32'(err), 32'd0);
    check_eq("s2_busy_hdr", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h51);
    check_wr("s2_good", base_wr + 2, 8'd0, 16'hBEEF);
    check_eq("s2_done_good", 32'(ndone - base_done), 32'd1);

    // Junk bytes before the header are ignored
    base_wr = nwr; base_done = ndone;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check_eq("s3_nwr_junk", 32'(nwr - base_wr), 32'd0);
    check_eq("s3_busy_junk", 32'(busy), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h34);
    check_eq("s3_nwr", 32'(nwr - base_wr), 32'd1);
    check_wr("s3_w0", base_wr, 8'd0, 16'hCAFE);
    check_eq("s3_done", 32'(ndone - base_done), 32'd1);

    // Framing error on the second data byte aborts the frame
    base_wr = nwr; base_done = ndone;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    send_byte(8'h34, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("s4_nwr", 32'(nwr - base_wr), 32'd0);
    check_eq("s4_err", 32'(err), 32'd1);
    check_eq("s4_busy", 32'(busy), 32'd0);
    check_eq("s4_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("s4_done", 32'(ndone - base_done), 32'd0);

    // Reset after the first word: outputs clear, nothing further written
    base_wr = nwr; base_done = ndone;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check_eq("s5_first", 32'(nwr - base_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("s5_rst");
    rst = 1'b0;
    repeat (CPB * 10) @(negedge clk);
    check_eq("s5_no_more", 32'(nwr - base_wr), 32'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h51);
    check_eq("s5_nwr", 32'(nwr - base_wr), 32'd2);
    check_wr("s5_fresh", base_wr + 1, 8'd0, 16'hBEEF);
    check_eq("s5_done", 32'(ndone - base_done), 32'd1);

    // N=0: 256 incrementing words; XOR of all bytes is 00
    base_wr = nwr; base_done = ndone;
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00);
      send_byte(8'(i));
    end
    send_byte(8'h00);
    check_eq("s6_nwr", 32'(nwr - base_wr), 32'd256);
    for (int i = 0; i < 256; i++) begin
      check_wr($sformatf("s6_w%0d", i), base_wr + i, 8'(i), 16'(i));
    end
    check_eq("s6_done", 32'(ndone - base_done), 32'd1);
    check_eq("s6_err", 32'(err), 32'd0);
    check_eq("wen_consec", 32'(nconsec), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
